// File: rtl/vga_fb_scanout_if.sv
// Framebuffer read bus between the VGA scanout and the framebuffer memory.
// The address is registered by the scanout; data is expected one clock later.
interface vga_fb_scanout_if #(
   parameter int BPC = 1
);
   logic [14:0]        rd_addr;
   logic [3*BPC-1:0]   rd_data;

   modport master (output rd_addr, input  rd_data);
   modport slave  (input  rd_addr, output rd_data);
endinterface

// File: rtl/vga_fb_scanout.sv
// 640x480@60 VGA scanout of a 160x120 framebuffer, upscaled 4x4, driving the ADV7123 DAC.
// Counter stage -> address stage -> pin stage; sync and blank travel alongside the pixel data.
module vga_fb_scanout #(
   parameter int H_VIS       = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_VIS       = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int SCALE_SHIFT = 2,
   parameter int FB_W        = 160,
   parameter int BPC         = 1
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   vga_fb_scanout_if.master  fb,
   output logic              frame_start,
   output logic              in_vblank,
   output logic              VGA_CLK,
   output logic              VGA_HS,
   output logic              VGA_VS,
   output logic              VGA_BLANK_N,
   output logic              VGA_SYNC_N,
   output logic [9:0]        VGA_R,
   output logic [9:0]        VGA_G,
   output logic [9:0]        VGA_B
);
   localparam logic [9:0] H_VIS_L = 10'(H_VIS);
   localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] V_VIS_L = 10'(V_VIS);
   localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);

   logic        phase;
   logic        tick;
   logic [9:0]  h_cnt, v_cnt;
   logic [9:0]  fb_x, fb_y;
   logic [14:0] y_ext, x_ext, pix_addr;
   logic [14:0] rd_addr;
   logic        hs_raw, vs_raw, vis;
   logic        hs_d1, vs_d1, vis_d1;

   function automatic logic [9:0] rep10(input logic [BPC-1:0] c);
      logic [9:0] r;
      r = '0;
      for (int i = 0; i < 10; i++)
         r[9-i] = c[BPC-1-(i % BPC)];
      return r;
   endfunction

   assign tick        = phase;
   assign VGA_CLK     = phase;
   assign VGA_SYNC_N  = 1'b0;
   assign fb.rd_addr  = rd_addr;

   assign frame_start = tick && (h_cnt == '0) && (v_cnt == '0);
   assign in_vblank   = (v_cnt >= V_VIS_L);

   assign hs_raw = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
   assign vs_raw = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
   assign vis    = (h_cnt < H_VIS_L) && (v_cnt < V_VIS_L);

   assign fb_x  = h_cnt >> SCALE_SHIFT;
   assign fb_y  = v_cnt >> SCALE_SHIFT;
   assign y_ext = 15'(fb_y);
   assign x_ext = 15'(fb_x);

   // 160 = 128 + 32, so the row offset needs only two shifted adds
   if (FB_W == 160) begin : g_shift_mul
      assign pix_addr = (y_ext << 7) + (y_ext << 5) + x_ext;
   end else begin : g_gen_mul
      assign pix_addr = 15'(y_ext * 15'(FB_W)) + x_ext;
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         phase       <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         rd_addr     <= '0;
         hs_d1       <= 1'b1;
         vs_d1       <= 1'b1;
         vis_d1      <= 1'b0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
      end else begin
         phase <= ~phase;
         if (tick) begin
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
               h_cnt <= h_cnt + 10'd1;
            end
            // address stage: only fetch inside the picture, hold otherwise
            if (vis)
               rd_addr <= pix_addr;
            hs_d1  <= hs_raw;
            vs_d1  <= vs_raw;
            vis_d1 <= vis;
            // pin stage: rd_data belongs to the address issued on the previous tick
            VGA_HS      <= hs_d1;
            VGA_VS      <= vs_d1;
            VGA_BLANK_N <= vis_d1;
            VGA_R       <= vis_d1 ? rep10(fb.rd_data[3*BPC-1 -: BPC]) : '0;
            VGA_G       <= vis_d1 ? rep10(fb.rd_data[2*BPC-1 -: BPC]) : '0;
            VGA_B       <= vis_d1 ? rep10(fb.rd_data[BPC-1   -: BPC]) : '0;
         end
      end
   end
endmodule
